// File: rtl/hmac_drbg_seed_loader_pkg.sv
// Shared types and constants for the DRBG seed loader.
// Default sizes track the hmac_drbg seed width.
package hmac_drbg_seed_loader_pkg;

  localparam int SEED_LENGTH_DEF = 384;
  localparam int WORD_W_DEF      = 32;
  localparam int SEED_WORDS      = SEED_LENGTH_DEF / WORD_W_DEF;

  localparam int RCT_CUTOFF_MIN  = 2;
  localparam int RCT_CUTOFF_MAX  = 15;

  localparam int WAIT_LOW_CYCLES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_ARM,
    ST_INIT,
    ST_WAIT_LOW,
    ST_WAIT_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/hmac_drbg_rct.sv
// Repetition-count health test on accepted entropy words.
// fail flags the word that brings the run length to the cutoff.
module hmac_drbg_rct
  import hmac_drbg_seed_loader_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int RCT_CUTOFF = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              accept,
  input  logic [WORD_W-1:0] data,
  output logic              fail
);

  localparam int CNT_W = $clog2(RCT_CUTOFF_MAX + 1);
  localparam logic [CNT_W-1:0] CUT = CNT_W'(RCT_CUTOFF);

  logic [WORD_W-1:0] prev;
  logic [CNT_W-1:0]  rep;
  logic [CNT_W-1:0]  rep_next;

  // rep == 0 means no word seen yet in this collection
  always_comb begin
    rep_next = CNT_W'(1);
    if (rep != '0 && data == prev) begin
      rep_next = (rep == '1) ? rep : rep + 1'b1;
    end
  end

  assign fail = accept && (rep_next >= CUT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
      rep  <= '0;
    end else if (clear) begin
      prev <= '0;
      rep  <= '0;
    end else if (accept) begin
      prev <= data;
      rep  <= rep_next;
    end
  end

endmodule

// File: rtl/hmac_drbg_seed_loader.sv
// Collects TRNG words into a seed and launches hmac_drbg.
// Seed is held stable from ARM until the DRBG reports done.
module hmac_drbg_seed_loader
  import hmac_drbg_seed_loader_pkg::*;
#(
  parameter int SEED_LENGTH = SEED_LENGTH_DEF,
  parameter int WORD_W      = WORD_W_DEF,
  parameter int RCT_CUTOFF  = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req,
  input  logic                   zeroize,
  input  logic                   ent_valid,
  input  logic [WORD_W-1:0]      ent_data,
  output logic                   ent_ready,
  input  logic                   drbg_ready,
  output logic                   drbg_init,
  output logic [SEED_LENGTH-1:0] seed,
  output logic                   seed_valid,
  output logic                   busy,
  output logic                   health_fail
);

  localparam int N = SEED_LENGTH / WORD_W;

  state_t state;
  state_t state_next;

  logic [3:0] word_cnt;
  logic [2:0] wait_cnt;
  logic       hs;
  logic       rct_fail;
  logic       last_word;
  logic [SEED_LENGTH-1:0] placed;

  assign hs        = ent_valid && (state == ST_COLLECT);
  assign last_word = (word_cnt == 4'(N - 1));

  // word k lands at the top minus k words
  assign placed = {ent_data, {(SEED_LENGTH - WORD_W){1'b0}}}
                  >> (int'(word_cnt) * WORD_W);

  hmac_drbg_rct #(
    .WORD_W     (WORD_W),
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (zeroize || state == ST_IDLE),
    .accept  (hs && !zeroize),
    .data    (ent_data),
    .fail    (rct_fail)
  );

  always_comb begin
    state_next = state;
    if (zeroize) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req) state_next = ST_COLLECT;
        end
        ST_COLLECT: begin
          if (hs && rct_fail) state_next = ST_ERROR;
          else if (hs && last_word) state_next = ST_ARM;
        end
        ST_ARM: begin
          if (drbg_ready) state_next = ST_INIT;
        end
        ST_INIT: state_next = ST_WAIT_LOW;
        ST_WAIT_LOW: begin
          if (!drbg_ready ||
              wait_cnt == 3'(WAIT_LOW_CYCLES - 1))
            state_next = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (drbg_ready) state_next = ST_IDLE;
        end
        ST_ERROR: state_next = ST_ERROR;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      wait_cnt <= '0;
      seed     <= '0;
    end else begin
      state <= state_next;
      if (state_next == ST_IDLE || state_next == ST_ERROR) begin
        seed     <= '0;
        word_cnt <= '0;
      end else if (hs) begin
        seed     <= seed | placed;
        word_cnt <= word_cnt + 4'd1;
      end
      if (state == ST_WAIT_LOW) wait_cnt <= wait_cnt + 3'd1;
      else wait_cnt <= '0;
    end
  end

  assign ent_ready   = (state == ST_COLLECT);
  assign drbg_init   = (state == ST_INIT);
  assign busy        = (state != ST_IDLE);
  assign health_fail = (state == ST_ERROR);
  assign seed_valid  = (state == ST_ARM) || (state == ST_INIT) ||
                       (state == ST_WAIT_LOW) ||
                       (state == ST_WAIT_DONE);

endmodule

// File: tb/tb_hmac_drbg_seed_loader.sv
// Scoreboard bench for hmac_drbg_seed_loader.
// Expected seeds are queued at stimulus and checked on drbg_init.
module tb_hmac_drbg_seed_loader;

  localparam int SL = 384;
  localparam int WW = 32;

  localparam logic [SL-1:0] NOM = {
    32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
    32'h00000005, 32'h00000006, 32'h00000007, 32'h00000008,
    32'h00000009, 32'h0000000A, 32'h0000000B, 32'h0000000C
  };
  localparam logic [SL-1:0] NEAR = {
    4{32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A}
  };

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req = 1'b0;
  logic          zeroize = 1'b0;
  logic          ent_valid = 1'b0;
  logic [WW-1:0] ent_data = '0;
  logic          drbg_ready = 1'b1;
  logic          ent_ready;
  logic          drbg_init;
  logic [SL-1:0] seed;
  logic          seed_valid;
  logic          busy;
  logic          health_fail;

  int errors = 0;
  int checks = 0;
  int inits  = 0;
  int cyc;

  logic [SL-1:0] exp_q[$];
  logic [SL-1:0] mon_exp;

  hmac_drbg_seed_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .zeroize     (zeroize),
    .ent_valid   (ent_valid),
    .ent_data    (ent_data),
    .ent_ready   (ent_ready),
    .drbg_ready  (drbg_ready),
    .drbg_init   (drbg_init),
    .seed        (seed),
    .seed_valid  (seed_valid),
    .busy        (busy),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n && drbg_init) begin
      inits++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL init_seed: unexpected drbg_init, seed %h", seed);
      end else begin
        mon_exp = exp_q.pop_front();
        if (seed !== mon_exp) begin
          errors++;
          $display("FAIL init_seed: got %h want %h", seed, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string name, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic chks(input string name, input logic [SL-1:0] act,
                      input logic [SL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic start();
    req = 1'b1;
    tick();
    req = 1'b0;
  endtask

  task automatic push_word(input logic [WW-1:0] d);
    int n;
    n = 0;
    ent_valid = 1'b1;
    ent_data  = d;
    while (!ent_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk1("ready_timeout", ent_ready, 1'b1);
    tick();
    ent_valid = 1'b0;
    ent_data  = 32'hDEADBEEF;
  endtask

  task automatic load(input logic [SL-1:0] s, input int gap);
    for (int k = 0; k < 12; k++) begin
      push_word(s[SL-1-k*WW -: WW]);
      if (k < 11) repeat (gap) tick();
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk1("return_idle", busy, 1'b0);
  endtask

  initial begin
    #1;
    chk1("rst_ready", ent_ready, 1'b0);
    chk1("rst_init", drbg_init, 1'b0);
    chks("rst_seed", seed, '0);
    chk1("rst_valid", seed_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_hfail", health_fail, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // nominal back-to-back load
    exp_q.push_back(NOM);
    start();
    chk1("ready_rise", ent_ready, 1'b1);
    load(NOM, 0);
    chk1("nom_arm_valid", seed_valid, 1'b1);
    chk1("nom_ready_fall", ent_ready, 1'b0);
    chk1("nom_arm_noinit", drbg_init, 1'b0);
    chks("nom_seed", seed, NOM);
    tick();
    chk1("nom_init", drbg_init, 1'b1);
    wait_idle(cyc);
    chki("nom_done_cycles", cyc, 6);
    chks("nom_seed_clr", seed, '0);
    chk1("nom_valid_clr", seed_valid, 1'b0);

    // throttled source
    exp_q.push_back(NOM);
    start();
    load(NOM, 1);
    chks("thr_seed", seed, NOM);
    wait_idle(cyc);

    // RCT trip
    start();
    push_word(32'hA5A5A5A5);
    push_word(32'hA5A5A5A5);
    push_word(32'hA5A5A5A5);
    chk1("rct_hfail", health_fail, 1'b1);
    chk1("rct_ready", ent_ready, 1'b0);
    chks("rct_seed", seed, '0);
    chk1("rct_valid", seed_valid, 1'b0);
    repeat (5) tick();
    chk1("rct_sticky", health_fail, 1'b1);
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    chk1("rct_zclr", health_fail, 1'b0);
    chk1("rct_zidle", busy, 1'b0);

    // RCT near-miss
    exp_q.push_back(NEAR);
    start();
    load(NEAR, 0);
    chk1("near_nofail", health_fail, 1'b0);
    chks("near_seed", seed, NEAR);
    wait_idle(cyc);

    // DRBG busy while armed
    drbg_ready = 1'b0;
    exp_q.push_back(NOM);
    start();
    load(NOM, 0);
    repeat (3) tick();
    chk1("busy_hold_valid", seed_valid, 1'b1);
    chk1("busy_hold_noinit", drbg_init, 1'b0);
    chks("busy_hold_seed", seed, NOM);
    drbg_ready = 1'b1;
    tick();
    chk1("busy_init", drbg_init, 1'b1);
    tick();
    drbg_ready = 1'b0;
    tick();
    repeat (6) tick();
    chk1("busy_wait_done", busy, 1'b1);
    chks("busy_wait_seed", seed, NOM);
    drbg_ready = 1'b1;
    tick();
    chk1("busy_to_idle", busy, 1'b0);

    // zeroize on the 6th handshake
    start();
    for (int k = 1; k <= 5; k++) push_word(WW'(k));
    ent_valid = 1'b1;
    ent_data  = 32'h00000006;
    zeroize   = 1'b1;
    tick();
    ent_valid = 1'b0;
    zeroize   = 1'b0;
    chk1("abort_idle", busy, 1'b0);
    chks("abort_seed", seed, '0);
    chk1("abort_ready", ent_ready, 1'b0);
    exp_q.push_back(NOM);
    start();
    load(NOM, 0);
    chks("abort_restart", seed, NOM);
    wait_idle(cyc);

    // async reset mid-collect
    start();
    for (int k = 1; k <= 3; k++) push_word(WW'(k));
    #3;
    reset_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_ready", ent_ready, 1'b0);
    chks("arst_seed", seed, '0);
    chk1("arst_valid", seed_valid, 1'b0);
    #2;
    reset_n = 1'b1;
    tick();
    repeat (3) tick();

    chki("init_count", inits, 5);
    chki("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hmac_drbg_seed_loader.md
# hmac_drbg_seed_loader

Upstream feeder for `hmac_drbg`. Collects 32-bit entropy words from the TRNG over a valid/ready stream and assembles them into a 384-bit seed. Each word passes a repetition-count health test. The loader then launches the DRBG with a one-cycle `init` pulse and holds the seed stable until the DRBG signals completion.

## Interface
Parameters:
- `SEED_LENGTH`, 384: seed width; must equal `hmac_drbg` `SEED_LENGTH`.
- `WORD_W`, 32: entropy word width; `SEED_LENGTH` must be a multiple of it.
- `RCT_CUTOFF`, 3: count of consecutive identical accepted words that trips the health test (legal range 2..15).

Ports:
- `clk`, in, 1: single clock domain.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: request a fresh seed. Sampled only in IDLE.
- `zeroize`, in, 1: synchronous clear to IDLE. Highest priority; also clears `health_fail`.
- `ent_valid`, in, 1: TRNG word valid.
- `ent_data`, in, `WORD_W`: TRNG word.
- `ent_ready`, out, 1: loader accepts a word this cycle.
- `drbg_ready`, in, 1: `hmac_drbg` ready output.
- `drbg_init`, out, 1: one-cycle start pulse to `hmac_drbg` init.
- `seed`, out, `SEED_LENGTH`: assembled seed to `hmac_drbg` seed.
- `seed_valid`, out, 1: seed complete and held stable.
- `busy`, out, 1: state is not IDLE.
- `health_fail`, out, 1: sticky RCT failure flag.

Reset values: all outputs 0 (`seed` all-zero).

## Operation
- N = `SEED_LENGTH`/`WORD_W` = 12 words per seed.
- States: IDLE, COLLECT, ARM, INIT, WAIT_LOW, WAIT_DONE, ERROR.
- IDLE:
  - `req`=1 → COLLECT.
  - On entry: word count cleared, RCT count cleared, `seed` cleared.
- COLLECT:
  - `ent_ready`=1.
  - Handshake = `ent_valid` & `ent_ready`.
  - Packing is MSB first: word k (0-based) lands in `seed[SEED_LENGTH-1-k*WORD_W -: WORD_W]`.
  - After accepting word N-1 → ARM.
- RCT (per collection):
  - Word 0 sets rep=1.
  - Each later accepted word equal to the previous accepted word gives rep+1; otherwise rep=1.
  - rep reaching `RCT_CUTOFF` → ERROR on the next edge. The failing word is not counted toward N.
- ARM: `seed_valid`=1. If `drbg_ready`=1 → INIT.
- INIT: `drbg_init`=1 for exactly this cycle → WAIT_LOW.
- WAIT_LOW: wait for `drbg_ready`=0 → WAIT_DONE. If `drbg_ready` is still 1 after 4 cycles, proceed to WAIT_DONE anyway; this handles a DRBG that finishes instantly.
- WAIT_DONE: `drbg_ready`=1 → IDLE (seed zeroed on entry).
- ERROR:
  - `ent_ready`=0, `health_fail`=1, `seed` zeroed, `seed_valid`=0.
  - Exit only via `zeroize` or reset.
- `req` outside IDLE is ignored; no queuing.
- `zeroize` in any state → IDLE next edge. Clears `seed`, counters and `health_fail`. Overrides a simultaneous handshake (the word is dropped) and a simultaneous `req`.
- `seed_valid`=1 in ARM, INIT, WAIT_LOW, WAIT_DONE. `seed` bits are constant throughout those states.

## Timing
- All outputs are registered or decoded directly from the state register; no combinational path from inputs to outputs.
- `ent_ready` rises the cycle after the `req` edge and falls the cycle after the N-th handshake.
- One word per cycle at most; 12 back-to-back words take 12 cycles.
- Minimum latency from the last handshake edge to the `drbg_init` high cycle is 2 cycles (ARM, then INIT), given `drbg_ready`=1.
- Reset asserted mid-operation clears everything immediately, asynchronously.
- The handshake is honoured on `ent_valid` only; `ent_data` is don't-care when `ent_valid`=0.

## Structure
- Put N, the state encoding localparams and the `RCT_CUTOFF` bounds in the shared `hmac_drbg_param.sv` include, next to the DRBG constants.
- One sub-module, `hmac_drbg_rct`: previous-word register plus saturating rep counter. Inputs are clear, accept and data; output is fail.
- The top holds the FSM, the word counter (4 bits) and the seed shift/packing register.

## Test plan
- Nominal load:
  - Stimulus: `req`, then words 0x00000001..0x0000000C back-to-back, with `drbg_ready` held at 1.
  - Response: `seed` = 0x00000001_00000002_…_0000000C; `seed_valid`=1; `drbg_init` pulses once, 2 cycles after the last handshake.
- Throttled source:
  - Stimulus: `ent_valid` toggling every other cycle.
  - Response: exactly 12 words accepted; `seed` identical to the nominal case; no duplicate or lost words.
- RCT trip:
  - Stimulus: words 0xA5A5A5A5 three times consecutively.
  - Response: ERROR, `health_fail`=1, `ent_ready`=0, `seed`=0, no `drbg_init`.
  - Follow-up: `zeroize` clears `health_fail` and returns to IDLE.
- RCT near-miss:
  - Stimulus: 0xA5A5A5A5, 0xA5A5A5A5, 0x5A5A5A5A, 0xA5A5A5A5 …
  - Response: no failure.
- DRBG busy:
  - Stimulus: `drbg_ready`=0 while in ARM.
  - Response: loader holds in ARM with seed stable; `drbg_init` issues 1 cycle after `drbg_ready` rises. Loader returns to IDLE only after `drbg_ready` falls and then rises again.
- Mid-operation abort:
  - Stimulus: `zeroize` asserted on the same cycle as the 6th handshake.
  - Response: IDLE next cycle, word dropped, `seed`=0. A following `req` restarts from word 0.
  - Repeat the case with asynchronous `reset_n` asserted mid-COLLECT: all outputs 0 immediately.
